// File: rtl/mdu_dispatch.sv
// mdu_dispatch: issue/response stage between execute and the M-extension multiply/divide unit.
// Optional: define RISCV_DIV_SPECIAL_EN to resolve divide-by-zero and signed overflow locally.
package mdu_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mul_op_t;
endpackage

module mdu_dispatch
    import mdu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  mul_op_t              req_op,
    input  logic [XLEN-1:0]      req_r1,
    input  logic [XLEN-1:0]      req_r2,
    input  logic [REG_IDX_W-1:0] req_rd_idx,

    output logic                 mul_en,
    output mul_op_t              mul_op,
    output logic [XLEN-1:0]      mul_r1,
    output logic [XLEN-1:0]      mul_r2,
    input  logic                 mul_busy,
    input  logic [XLEN-1:0]      mul_rd,

    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [REG_IDX_W-1:0] wb_rd_idx,
    output logic [XLEN-1:0]      wb_data,

    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        RESP
    } state_t;

    state_t state;
    logic   kill;
    logic   accept;
    logic   special;
    logic [XLEN-1:0] special_res;

    // The unit has no reset, so a run left over from before reset must finish first.
    assign req_ready = (state == IDLE) && !mul_busy && !flush;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);

`ifdef RISCV_DIV_SPECIAL_EN
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic r2_zero;
    logic overflow;
    logic is_div;
    logic is_rem;

    always_comb begin
        r2_zero     = (req_r2 == '0);
        overflow    = (req_r1 == MIN_INT) && (req_r2 == '1);
        is_div      = (req_op == OP_DIV) || (req_op == OP_DIVU);
        is_rem      = (req_op == OP_REM) || (req_op == OP_REMU);
        special     = 1'b0;
        special_res = '0;
        if ((is_div || is_rem) && r2_zero) begin
            special     = 1'b1;
            special_res = is_div ? '1 : req_r1;
        end else if ((req_op == OP_DIV) && overflow) begin
            special     = 1'b1;
            special_res = MIN_INT;
        end else if ((req_op == OP_REM) && overflow) begin
            special     = 1'b1;
            special_res = '0;
        end
    end
`else
    assign special     = 1'b0;
    assign special_res = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            kill      <= 1'b0;
            mul_en    <= 1'b0;
            mul_op    <= OP_MUL;
            mul_r1    <= '0;
            mul_r2    <= '0;
            wb_valid  <= 1'b0;
            wb_rd_idx <= '0;
            wb_data   <= '0;
        end else begin
            mul_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_op    <= req_op;
                        mul_r1    <= req_r1;
                        mul_r2    <= req_r2;
                        wb_rd_idx <= req_rd_idx;
                        if (special) begin
                            wb_data  <= special_res;
                            wb_valid <= 1'b1;
                            state    <= RESP;
                        end else begin
                            mul_en <= 1'b1;
                            state  <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    state <= WAIT_HI;
                end

                WAIT_HI: begin
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    if (mul_busy) begin
                        state <= WAIT_LO;
                    end
                end

                // A flush arriving on the drain cycle itself still kills the response.
                WAIT_LO: begin
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    if (!mul_busy) begin
                        wb_data <= mul_rd;
                        if (kill || flush) begin
                            kill  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            wb_valid <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (flush || wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_dispatch.sv
// tb_mdu_dispatch: directed scoreboard bench for mdu_dispatch driving a behavioural multiply/divide unit.
module tb_mdu_dispatch;
    import mdu_pkg::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    mul_op_t     req_op = OP_MUL;
    logic [31:0] req_r1 = '0;
    logic [31:0] req_r2 = '0;
    logic [4:0]  req_rd_idx = '0;
    logic        mul_en;
    mul_op_t     mul_op;
    logic [31:0] mul_r1;
    logic [31:0] mul_r2;
    logic        mul_busy;
    logic [31:0] mul_rd;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_data;
    logic        busy;

    wb_exp_t     exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          en_count = 0;
    int          unit_cnt = 0;
    int          busy_len = 1;
    logic        force_busy = 1'b0;
    logic [31:0] unit_res = '0;

    mdu_dispatch #(.XLEN(32), .REG_IDX_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_r1     (req_r1),
        .req_r2     (req_r2),
        .req_rd_idx (req_rd_idx),
        .mul_en     (mul_en),
        .mul_op     (mul_op),
        .mul_r1     (mul_r1),
        .mul_r2     (mul_r2),
        .mul_busy   (mul_busy),
        .mul_rd     (mul_rd),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd_idx  (wb_rd_idx),
        .wb_data    (wb_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural unit: RISC-V M semantics, busy for busy_len cycles after each start pulse.
    function automatic logic [31:0] unitCalc(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic [31:0]        r;
        r = '0;
        case (op)
            OP_MUL:    begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
            OP_MULH:   begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp[63:32]; end
            OP_MULHSU: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = sp[63:32]; end
            OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            OP_DIV: begin
                if (b == '0) r = '1;
                else if (a == 32'h8000_0000 && b == '1) r = a;
                else r = $signed(a) / $signed(b);
            end
            OP_DIVU: begin
                if (b == '0) r = '1;
                else r = a / b;
            end
            OP_REM: begin
                if (b == '0) r = a;
                else if (a == 32'h8000_0000 && b == '1) r = '0;
                else r = $signed(a) % $signed(b);
            end
            OP_REMU: begin
                if (b == '0) r = a;
                else r = a % b;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (mul_en) begin
            en_count <= en_count + 1;
            unit_cnt <= busy_len;
            unit_res <= unitCalc(mul_op, mul_r1, mul_r2);
        end else if (unit_cnt > 0) begin
            unit_cnt <= unit_cnt - 1;
        end
    end

    assign mul_busy = force_busy || (unit_cnt > 0);
    assign mul_rd   = unit_res;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed writeback transfer is matched against the scoreboard.
    always @(negedge clk) begin : monitor
        wb_exp_t e;
        if (!rst && wb_valid && wb_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL wb_unexpected got rd=%0d data=%h expected no transfer", wb_rd_idx, wb_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wb_data", wb_data, e.data);
                checkOutput("wb_rd_idx", 32'(wb_rd_idx), 32'(e.rd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call just after a rising edge; returns one step into the cycle after the accept edge.
    task automatic applyStimulus(input mul_op_t op, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [4:0] rd);
        int n = 0;
        req_op     = op;
        req_r1     = r1;
        req_r2     = r2;
        req_rd_idx = rd;
        req_valid  = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout got req_ready=0 expected 1 within 50 cycles");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic waitWb();
        int n = 0;
        @(negedge clk);
        while (!wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wb_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL wb_timeout got wb_valid=0 expected 1 within 20 cycles");
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int      en0;
        int      n;
        logic    saw_valid;
        mul_op_t sp_op [4];
        logic [31:0] sp_r1 [4];
        logic [31:0] sp_r2 [4];
        logic [31:0] sp_exp [4];

        #2;
        checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset_mul_en", 32'(mul_en), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

        // MUL 7 * -3 through the unit with the nominal 5-cycle schedule
        $display("[TB] MUL latency");
        wb_ready = 1'b1;
        en0 = en_count;
        tick();
        exp_q.push_back('{rd: 5'd5, data: 32'hFFFF_FFEB});
        applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        @(negedge clk);
        checkOutput("a1_mul_en", 32'(mul_en), 32'd1);
        checkOutput("a1_mul_r2", mul_r2, 32'hFFFF_FFFD);
        checkOutput("a1_busy", 32'(busy), 32'd1);
        tick(); @(negedge clk);
        checkOutput("a2_mul_en", 32'(mul_en), 32'd0);
        tick(); @(negedge clk);
        checkOutput("a3_wb_valid", 32'(wb_valid), 32'd0);
        tick(); @(negedge clk);
        checkOutput("a4_wb_valid", 32'(wb_valid), 32'd1);
        tick(); @(negedge clk);
        checkOutput("a5_busy", 32'(busy), 32'd0);
        checkOutput("mul_en_pulses", 32'(en_count - en0), 32'd1);

        // MULHU with writeback stalled for three cycles
        $display("[TB] MULHU backpressure");
        tick();
        wb_ready = 1'b0;
        exp_q.push_back('{rd: 5'd9, data: 32'hFFFF_FFFE});
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
        waitWb();
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_wb_valid", 32'(wb_valid), 32'd1);
            checkOutput("stall_wb_data", wb_data, 32'hFFFF_FFFE);
            checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
            if (i < 2) @(negedge clk);
        end
        tick();
        wb_ready = 1'b1;
        tick(); @(negedge clk);
        checkOutput("post_hs_req_ready", 32'(req_ready), 32'd1);
        checkOutput("post_hs_wb_valid", 32'(wb_valid), 32'd0);

`ifdef RISCV_DIV_SPECIAL_EN
        // Locally resolved divide corner cases: one-cycle latency, unit untouched
        $display("[TB] divide special cases");
        sp_op  = '{OP_DIV, OP_REM, OP_DIV, OP_REM};
        sp_r1  = '{32'h64, 32'h64, 32'h8000_0000, 32'h8000_0000};
        sp_r2  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        sp_exp = '{32'hFFFF_FFFF, 32'h64, 32'h8000_0000, 32'h0};
        en0 = en_count;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_q.push_back('{rd: 5'(10 + i), data: sp_exp[i]});
            applyStimulus(sp_op[i], sp_r1[i], sp_r2[i], 5'(10 + i));
            @(negedge clk);
            checkOutput("special_wb_valid_a1", 32'(wb_valid), 32'd1);
            checkOutput("special_mul_en", 32'(mul_en), 32'd0);
            tick();
        end
        checkOutput("special_no_unit", 32'(en_count - en0), 32'd0);
`endif

        // DIVU killed by flush while waiting for the unit to start
        $display("[TB] flush in WAIT_HI");
        busy_len = 3;
        tick();
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd6);
        tick();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_busy", 32'(busy), 32'd1);
        tick();
        flush = 1'b0;
        saw_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            if (wb_valid) saw_valid = 1'b1;
            @(negedge clk);
            n++;
        end
        checkOutput("killed_wb_valid", 32'(saw_valid | wb_valid), 32'd0);
        checkOutput("killed_busy_falls", 32'(busy), 32'd0);
        checkOutput("killed_unit_drained", 32'(mul_busy), 32'd0);
        busy_len = 1;
        tick();
        exp_q.push_back('{rd: 5'd7, data: 32'd14});
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd7);
        waitWb();
        tick();

        // Flush in RESP: alone, then together with wb_ready
        $display("[TB] flush in RESP");
        for (int k = 0; k < 2; k++) begin
            wb_ready = 1'b0;
            tick();
            applyStimulus(OP_MUL, 32'd3, 32'd4, 5'd2);
            waitWb();
            tick();
            flush = 1'b1;
            wb_ready = (k == 1);
            tick();
            flush = 1'b0;
            @(negedge clk);
            checkOutput("resp_flush_wb_valid", 32'(wb_valid), 32'd0);
            checkOutput("resp_flush_busy", 32'(busy), 32'd0);
        end
        wb_ready = 1'b1;

        // Reset while the unit is running, then a stuck-busy unit after reset
        $display("[TB] reset in WAIT_LO");
        busy_len = 3;
        tick();
        applyStimulus(OP_MUL, 32'h11, 32'h3, 5'd4);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mul_r1", mul_r1, 32'd0);
        checkOutput("rst_mul_r2", mul_r2, 32'd0);
        checkOutput("rst_mul_op", 32'(mul_op), 32'd0);
        checkOutput("rst_wb_rd_idx", 32'(wb_rd_idx), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        force_busy = 1'b1;
        req_op = OP_MUL; req_r1 = 32'd2; req_r2 = 32'd2; req_rd_idx = 5'd1;
        req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("stuck_busy_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        force_busy = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("released_req_ready", 32'(req_ready), 32'd1);
        busy_len = 1;
        tick();
        exp_q.push_back('{rd: 5'd31, data: 32'd1});
        applyStimulus(OP_MULH, 32'h0001_0000, 32'h0001_0000, 5'd31);
        waitWb();

        repeat (3) tick();
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
